// File: rtl/regfile_pkg.sv
// Shared register-file constants and the write-back entry carried through the B FIFO.
package regfile_pkg;
  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;
  localparam int XLEN     = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Small FIFO for multi-cycle results waiting for the shared register-file write port.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      Clk,
  input  logic      Reset,
  input  logic      push_i,
  input  wb_entry_t push_data_i,
  input  logic      pop_i,
  output wb_entry_t head_o,
  output logic      full_o,
  output logic      empty_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULLC = CW'(DEPTH);

  wb_entry_t         mem_q [DEPTH];
  logic [PW-1:0]     wr_q, rd_q;
  logic [CW-1:0]     cnt_q;
  logic              do_push, do_pop;

  assign full_o  = (cnt_q == FULLC);
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];
  // No push-through: a full FIFO refuses even when it pops this cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= (wr_q == LAST) ? '0 : wr_q + PW'(1);
      end
      if (do_pop) rd_q <= (rd_q == LAST) ? '0 : rd_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: arbitrates pipeline (A) and multi-cycle (B) results onto the
// single register-file write port and tracks pending long-latency destinations.
module regfile_wb_ctrl
  import regfile_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              a_valid,
  input  logic [REG_AW-1:0] a_rd,
  input  logic [XLEN-1:0]   a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [REG_AW-1:0] b_rd,
  input  logic [XLEN-1:0]   b_data,
  output logic              b_ready,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_rd,
  output logic              iss_ready,
  input  logic [REG_AW-1:0] RX,
  input  logic [REG_AW-1:0] RY,
  output logic              hz_stall,
  output logic              WEN,
  output logic [REG_AW-1:0] RW,
  output logic [XLEN-1:0]   busW
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

  wb_entry_t           b_in, head;
  logic                full, empty;
  logic                force_b, b_gnt, a_gnt;
  logic [SW-1:0]       starve_q, starve_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [REG_AW-1:0]   gnt_rd;
  logic [XLEN-1:0]     gnt_data;

  assign b_in    = '{rd: b_rd, data: b_data};
  assign b_ready = !full;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .Clk         (Clk),
    .Reset       (Reset),
    .push_i      (b_valid && b_ready),
    .push_data_i (b_in),
    .pop_i       (b_gnt),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty)
  );

  // B only wins an idle slot unless it has waited STARVE_LIMIT lost cycles.
  assign force_b = !empty && (starve_q == SLIM);
  assign b_gnt   = !empty && (!a_valid || force_b);
  assign a_gnt   = a_valid && !force_b;
  assign a_ready = !force_b;

  always_comb begin
    gnt_rd   = '0;
    gnt_data = '0;
    if (b_gnt) begin
      gnt_rd   = head.rd;
      gnt_data = head.data;
    end else if (a_gnt) begin
      gnt_rd   = a_rd;
      gnt_data = a_data;
    end
  end

  assign WEN  = (a_gnt || b_gnt) && (gnt_rd != '0);
  assign RW   = gnt_rd;
  assign busW = gnt_data;

  always_comb begin
    starve_d = starve_q;
    if (b_gnt || empty)           starve_d = '0;
    else if (a_gnt && starve_q != SLIM) starve_d = starve_q + SW'(1);
  end

  // Issue to a busy rd is refused, so a set and clear never target the same bit.
  assign iss_ready = !((iss_rd != '0) && busy_q[iss_rd]);
  assign hz_stall  = busy_q[RX] | busy_q[RY];

  always_comb begin
    busy_d = busy_q;
    if (b_gnt) busy_d[head.rd] = 1'b0;
    if (iss_valid && iss_ready && iss_rd != '0) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      starve_q <= '0;
      busy_q   <= '0;
    end else begin
      starve_q <= starve_d;
      busy_q   <= busy_d;
    end
  end
endmodule
